// File: rtl/draw_pkg.sv
// Shared screen geometry, pixel field widths and arbiter state encoding
// for the VGA drawing engines.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = $clog2(SCREEN_W);
    localparam int Y_W      = $clog2(SCREEN_H);
    localparam int COLOR_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request found scanning
// upward from ptr+1 and wrapping, so ptr itself has the lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Shares the single VGA pixel write port among NUM_REQ draw engines with a
// round-robin grant held until the owner finishes, aborts or times out.
module draw_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = draw_pkg::X_W,
    parameter int Y_W     = draw_pkg::Y_W,
    parameter int COLOR_W = draw_pkg::COLOR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    input  logic [NUM_REQ-1:0]         req_plot,
    output logic [NUM_REQ-1:0]         grant,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [COLOR_W-1:0]         color_out,
    output logic                       plot_out,
    output logic                       busy,
    output logic                       timeout_err
);

    import draw_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic             owner_exit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    assign timed_out  = (cnt == CNT_LAST);
    assign owner_exit = done[owner] | ~req[owner] | timed_out;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid)  next_state = ACTIVE;
            ACTIVE:  if (owner_exit) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The cycle that sees the owner's done still forwards its pixel; RELEASE then quiets the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            owner       <= '0;
            ptr         <= IDX_W'(NUM_REQ - 1);
            x_out       <= '0;
            y_out       <= '0;
            color_out   <= '0;
            plot_out    <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot_out <= 1'b0;
                    cnt      <= '0;
                    if (win_valid) begin
                        grant <= NUM_REQ'(1) << winner;
                        owner <= winner;
                        ptr   <= winner;
                    end
                end
                ACTIVE: begin
                    x_out     <= req_x[owner*X_W +: X_W];
                    y_out     <= req_y[owner*Y_W +: Y_W];
                    color_out <= req_color[owner*COLOR_W +: COLOR_W];
                    plot_out  <= req_plot[owner];
                    if (!timed_out)  cnt <= cnt + 1'b1;
                    if (timed_out)   timeout_err <= 1'b1;
                    if (owner_exit)  grant <= '0;
                end
                default: begin
                    grant    <= '0;
                    plot_out <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter: a long-timeout instance for normal
// traffic and a TIMEOUT=16 instance sharing the same inputs for forced release.
module tb_draw_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_color;
    logic [3:0]  req_plot;

    logic [3:0]  grant,     grant_t;
    logic [7:0]  x_out,     x_out_t;
    logic [6:0]  y_out,     y_out_t;
    logic [2:0]  color_out, color_out_t;
    logic        plot_out,  plot_out_t;
    logic        busy,      busy_t;
    logic        timeout_err, timeout_err_t;

    int n_compared;
    int n_mismatched;

    draw_port_arbiter #(.NUM_REQ(4), .X_W(8), .Y_W(7), .COLOR_W(3), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .req_plot(req_plot), .grant(grant), .x_out(x_out),
        .y_out(y_out), .color_out(color_out), .plot_out(plot_out), .busy(busy),
        .timeout_err(timeout_err)
    );

    draw_port_arbiter #(.NUM_REQ(4), .X_W(8), .Y_W(7), .COLOR_W(3), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .req_plot(req_plot), .grant(grant_t), .x_out(x_out_t),
        .y_out(y_out_t), .color_out(color_out_t), .plot_out(plot_out_t), .busy(busy_t),
        .timeout_err(timeout_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; done = '0; req_x = '0; req_y = '0; req_color = '0; req_plot = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if ({grant, x_out, y_out, color_out, plot_out, busy, timeout_err} !== 25'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {grant, x_out, y_out, color_out, plot_out, busy, timeout_err});
        end
        n_compared++;
        if ({grant_t, x_out_t, y_out_t, color_out_t, plot_out_t, busy_t, timeout_err_t} !== 25'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs_t: got %h expected 0",
                     {grant_t, x_out_t, y_out_t, color_out_t, plot_out_t, busy_t, timeout_err_t});
        end
        step();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_no_req: got grant=%b busy=%b expected 0000/0", grant, busy);
        end
    endtask

    task automatic test_single_engine();
        int plots;
        do_reset();
        req = 4'b0001;
        step();
        n_compared++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL grant_latency: got grant=%b busy=%b expected 0001/1", grant, busy);
        end
        plots = 0;
        for (int p = 0; p < 45; p++) begin
            req_x[7:0]     = 8'(p + 3);
            req_y[6:0]     = 7'(p * 2);
            req_color[2:0] = 3'(p);
            req_plot[0]    = 1'b1;
            done[0]        = (p == 44);
            step();
            if (plot_out) plots++;
            n_compared++;
            if (x_out !== 8'(p + 3) || y_out !== 7'(p * 2) || color_out !== 3'(p) || plot_out !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL pixel_%0d: got x=%0d y=%0d c=%0d plot=%b expected x=%0d y=%0d c=%0d plot=1",
                         p, x_out, y_out, color_out, plot_out, p + 3, p * 2, p % 8);
            end
            if (p < 44) begin
                n_compared++;
                if (grant !== 4'b0001) begin
                    n_mismatched++;
                    $display("[TB] FAIL grant_hold_%0d: got %b expected 0001", p, grant);
                end
            end
        end
        n_compared++;
        if (grant !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL grant_after_done: got %b expected 0000", grant);
        end
        done = '0; req_plot = '0; req = '0;
        step();
        n_compared++;
        if (plot_out !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL after_release: got plot=%b busy=%b expected 0/0", plot_out, busy);
        end
        n_compared++;
        if (plots !== 45) begin
            n_mismatched++;
            $display("[TB] FAIL plot_count: got %0d expected 45", plots);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int gap;
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            gap = 0;
            while (grant === 4'b0000 && gap < 8) begin
                gap++;
                step();
            end
            if (g > 0) begin
                n_compared++;
                if (gap !== 2) begin
                    n_mismatched++;
                    $display("[TB] FAIL rr_gap_%0d: got %0d idle cycles expected 2", g, gap);
                end
            end
            n_compared++;
            if (grant !== 4'(1 << exp_order[g])) begin
                n_mismatched++;
                $display("[TB] FAIL rr_order_%0d: got %b expected %b", g, grant, 4'(1 << exp_order[g]));
            end
            repeat (9) step();
            done[exp_order[g]] = 1'b1;
            step();
            done = '0;
        end
        req = '0;
        repeat (2) step();
    endtask

    task automatic test_ignore_non_owner();
        do_reset();
        req = 4'b0100;
        step();
        n_compared++;
        if (grant !== 4'b0100) begin
            n_mismatched++;
            $display("[TB] FAIL owner2_grant: got %b expected 0100", grant);
        end
        for (int i = 0; i < 4; i++) begin
            req_x[16 +: 8]    = 8'(10 + i);
            req_y[14 +: 7]    = 7'(20 + i);
            req_color[6 +: 3] = 3'd5;
            req_plot[2]       = (i % 2 == 1);
            req_x[8 +: 8]     = 8'(200 - i);
            req_y[7 +: 7]     = 7'd100;
            req_color[3 +: 3] = 3'd2;
            req_plot[1]       = 1'b1;
            done[1]           = 1'b1;
            step();
            n_compared++;
            if (x_out !== 8'(10 + i) || y_out !== 7'(20 + i) || color_out !== 3'd5 ||
                plot_out !== (i % 2 == 1) || grant !== 4'b0100) begin
                n_mismatched++;
                $display("[TB] FAIL ignore_%0d: got x=%0d y=%0d c=%0d plot=%b grant=%b expected x=%0d y=%0d c=5 plot=%0d grant=0100",
                         i, x_out, y_out, color_out, plot_out, grant, 10 + i, 20 + i, i % 2);
            end
        end
        done = 4'b0100; req_plot = '0;
        step();
        n_compared++;
        if (grant !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL owner2_release: got %b expected 0000", grant);
        end
        done = '0; req = '0;
        step();
    endtask

    task automatic test_timeout();
        int active;
        do_reset();
        req = 4'b1000;
        step();
        n_compared++;
        if (grant_t !== 4'b1000 || timeout_err_t !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL to_grant: got grant=%b err=%b expected 1000/0", grant_t, timeout_err_t);
        end
        active = 1;
        step();
        while (grant_t === 4'b1000 && active < 40) begin
            active++;
            step();
        end
        n_compared++;
        if (active !== 16) begin
            n_mismatched++;
            $display("[TB] FAIL to_active_cycles: got %0d expected 16", active);
        end
        n_compared++;
        if (timeout_err_t !== 1'b1 || busy_t !== 1'b1 || plot_out_t !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL to_release: got err=%b busy=%b plot=%b expected 1/1/0", timeout_err_t, busy_t, plot_out_t);
        end
        req = 4'b0010;
        repeat (2) step();
        n_compared++;
        if (grant_t !== 4'b0010 || timeout_err_t !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL to_next_grant: got grant=%b err=%b expected 0010/1", grant_t, timeout_err_t);
        end
        done = 4'b0010;
        step();
        done = '0; req = '0;
        repeat (3) step();
        n_compared++;
        if (timeout_err_t !== 1'b1 || busy_t !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL to_sticky: got err=%b busy=%b expected 1/0", timeout_err_t, busy_t);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        step();
        for (int p = 0; p < 20; p++) begin
            req_x[7:0]     = 8'(p + 1);
            req_y[6:0]     = 7'(p + 5);
            req_color[2:0] = 3'd6;
            req_plot[0]    = 1'b1;
            step();
        end
        n_compared++;
        if (x_out !== 8'd20 || y_out !== 7'd24 || color_out !== 3'd6 || plot_out !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset_pixel: got x=%0d y=%0d c=%0d plot=%b expected 20/24/6/1",
                     x_out, y_out, color_out, plot_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if (grant !== 4'b0000 || x_out !== 8'd0 || y_out !== 7'd0 || color_out !== 3'd0 ||
            plot_out !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got grant=%b x=%0d y=%0d c=%0d plot=%b busy=%b expected all 0",
                     grant, x_out, y_out, color_out, plot_out, busy);
        end
        req = 4'b1111; req_plot = '0;
        #2 rst_n = 1'b1;
        step();
        n_compared++;
        if (grant !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_first: got %b expected 0001", grant);
        end
        do_reset();
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0001;
        step();
        n_compared++;
        if (grant !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL abort_grant: got %b expected 0001", grant);
        end
        repeat (2) step();
        req = 4'b1110;
        step();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL abort_release: got grant=%b busy=%b expected 0000/1", grant, busy);
        end
        req = 4'b1111;
        step();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_idle: got grant=%b busy=%b expected 0000/0", grant, busy);
        end
        step();
        n_compared++;
        if (grant !== 4'b0010) begin
            n_mismatched++;
            $display("[TB] FAIL abort_ptr_advance: got %b expected 0010", grant);
        end
        do_reset();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        req = '0; done = '0; req_x = '0; req_y = '0; req_color = '0; req_plot = '0;
        test_reset();
        test_single_engine();
        test_round_robin();
        test_ignore_non_owner();
        test_timeout();
        test_async_reset();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
